inst_fetch_sequencer: RTL
=========================

// Module: inst_fetch_sequencer
// PURPOSE
//  Instruction initiator for the S-Machine CPU. Fetches 16-bit words from program memory
//  and handles control opcodes (NOP/JMP/HALT) locally. Issues every other opcode to the
//  instruction interpreter over the inst/start/done handshake.
//  Sits between program memory and the interpreter. Owns the architectural fetch PC.
// PARAMETERS
//  ADDR_W        8     program address width; PC wraps modulo 2**ADDR_W
//  INST_W        16    instruction width; opcode = inst[INST_W-1:INST_W-4]
//  RESET_PC      0     PC value loaded on reset
//  DONE_TIMEOUT  255   max cycles in WAIT_DONE before fault (>=1)
// PORTS
//  clk        in   1       rising-edge clock, sole clock
//  rst        in   1       synchronous, active-high reset
//  run        in   1       level; 1 = leave IDLE and sequence; sampled in IDLE only
//  mem_rd     out  1       read request, held until mem_valid
//  mem_addr   out  ADDR_W  read address (= pc while mem_rd)
//  mem_data   in   INST_W  read data, valid when mem_valid
//  mem_valid  in   1       read data strobe, any latency >=1 cycle after mem_rd
//  inst       out  INST_W  instruction to interpreter, stable from start until done
//  start      out  1       one-cycle issue pulse
//  done       in   1       interpreter completion, honoured only in WAIT_DONE
//  pc         out  ADDR_W  address of current/next instruction
//  halted     out  1       1 in HALT
//  fault      out  1       1 in FAULT (done timeout)
// BEHAVIOUR
//  Reset: state=IDLE, pc=RESET_PC, mem_rd=0, mem_addr=RESET_PC, inst=0, start=0, halted=0,
//   fault=0, timeout counter=0. Reset wins over every event in the same cycle.
//  Reset mid-operation abandons any outstanding read or issue. A late mem_valid or done is ignored.
//  All outputs are registered.
//  States: IDLE, FETCH, ISSUE, WAIT_DONE, HALT, FAULT.
//  IDLE:  run=1 -> FETCH next cycle, mem_rd=1, mem_addr=pc.
//  FETCH: hold mem_rd/mem_addr until mem_valid.
//   On mem_valid, decode mem_data[15:12] and drop mem_rd:
//   0000 NOP  -> pc=pc+1, stay FETCH (new request next cycle)
//   0001 JMP  -> pc=mem_data[ADDR_W-1:0], stay FETCH
//   1111 HALT -> HALT, pc unchanged (points at HALT word)
//   other     -> inst=mem_data, ISSUE
//  mem_valid outside FETCH (or with mem_rd=0) is ignored.
//  ISSUE: start=1 for exactly one cycle -> WAIT_DONE, counter cleared.
//  WAIT_DONE: done=1 -> pc=pc+1, FETCH (next request in the following cycle).
//   Counter increments each cycle without done. Reaching DONE_TIMEOUT -> FAULT.
//   done arriving in the same cycle the counter reaches DONE_TIMEOUT counts as success.
//  done is never taken in the start cycle. Minimum issue-to-next-fetch latency is 2 cycles.
//  Best-case throughput is 1 issued instruction per 4 cycles + memory latency + interpreter latency.
//  pc increment wraps at 2**ADDR_W-1 -> 0. JMP target is truncated to ADDR_W bits.
//  run is ignored outside IDLE: deasserting run mid-program does not stop the sequencer.
//  HALT and FAULT are sticky until rst.
//  inst keeps its last issued value in every state. start=0 in all states except ISSUE.
// CONFIGURATION
//  SEQ_RETIRE_COUNT_EN defined: adds port retired out 16, reset 0.
//   It increments by 1 on each accepted done, wraps at 16'hFFFF -> 0.
//   NOP and JMP are not counted.
//  SEQ_RETIRE_COUNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1. rst, run=1, mem={2005,4000,F000}, 1-cycle mem, done 2 cycles after start
//     -> two start pulses, inst=2005 then 4000; halted=1, pc=2.
//  2. mem[0]=0000, mem[1]=1010, mem[0x10]=F000
//     -> no start pulse; pc sequence 0,1,0x10; halted=1, pc=0x10.
//  3. mem[0]=5000, done never asserted, DONE_TIMEOUT=4
//     -> fault=1 exactly 4 cycles after the WAIT_DONE entry; start pulsed once; mem_rd=0 after.
//  4. RESET_PC=0xFF, mem[0xFF]=6000, mem[0]=F000
//     -> after done pc wraps to 0; halted=1, pc=0.
//  5. rst asserted in WAIT_DONE, done pulsed 1 cycle later with run=0
//     -> state IDLE, pc=RESET_PC, start=0, no pc change.
//  6. SEQ_RETIRE_COUNT_EN, program 3 ALU ops + NOP + HALT
//     -> retired=3; variable mem latency 1..5 gives identical inst order.

Source files
------------

// File: rtl/inst_fetch_sequencer_if.sv
// Program-memory read bus and interpreter issue handshake of the S-Machine fetch sequencer.
// master = sequencer side, slave = memory/interpreter side.
interface inst_fetch_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int INST_W = 16
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [INST_W-1:0] mem_data;
    logic              mem_valid;
    logic [INST_W-1:0] inst;
    logic              start;
    logic              done;

    modport master (
        output mem_rd, mem_addr, inst, start,
        input  mem_data, mem_valid, done
    );

    modport slave (
        input  mem_rd, mem_addr, inst, start,
        output mem_data, mem_valid, done
    );
endinterface

// File: rtl/inst_fetch_sequencer.sv
// S-Machine instruction fetch sequencer: fetches words, runs NOP/JMP/HALT locally, issues the rest.
// Optional retired-instruction counter port enabled by defining SEQ_RETIRE_COUNT_EN.
module inst_fetch_sequencer #(
    parameter int                ADDR_W       = 8,
    parameter int                INST_W       = 16,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0,
    parameter int                DONE_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    inst_fetch_sequencer_if.master bus,
    output logic [ADDR_W-1:0]     pc,
    output logic                  halted,
    output logic                  fault
`ifdef SEQ_RETIRE_COUNT_EN
    ,
    output logic [15:0]           retired
`endif
);

    localparam int CNT_W = (DONE_TIMEOUT < 1) ? 1 : $clog2(DONE_TIMEOUT + 1);
    // Last counter value before the timeout fires; comparing against it avoids a wider adder.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((DONE_TIMEOUT < 1) ? 0 : DONE_TIMEOUT - 1);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_JMP  = 4'h1;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT_DONE,
        HALT,
        FAULT
    } state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [ADDR_W-1:0] pc_next;
    logic              rd_next;
    logic [ADDR_W-1:0] addr_next;
    logic [INST_W-1:0] inst_next;
    logic              start_next;
    logic              halted_next;
    logic              fault_next;
    logic [3:0]        opcode;
`ifdef SEQ_RETIRE_COUNT_EN
    logic [15:0]       retired_next;
`endif

    assign opcode = bus.mem_data[INST_W-1 -: 4];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            pc           <= RESET_PC;
            bus.mem_rd   <= 1'b0;
            bus.mem_addr <= RESET_PC;
            bus.inst     <= '0;
            bus.start    <= 1'b0;
            halted       <= 1'b0;
            fault        <= 1'b0;
`ifdef SEQ_RETIRE_COUNT_EN
            retired      <= '0;
`endif
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            pc           <= pc_next;
            bus.mem_rd   <= rd_next;
            bus.mem_addr <= addr_next;
            bus.inst     <= inst_next;
            bus.start    <= start_next;
            halted       <= halted_next;
            fault        <= fault_next;
`ifdef SEQ_RETIRE_COUNT_EN
            retired      <= retired_next;
`endif
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        pc_next     = pc;
        rd_next     = bus.mem_rd;
        addr_next   = bus.mem_addr;
        inst_next   = bus.inst;
        halted_next = halted;
        fault_next  = fault;
`ifdef SEQ_RETIRE_COUNT_EN
        retired_next = retired;
`endif

        case (state)
            IDLE: begin
                if (run) begin
                    state_next = FETCH;
                    rd_next    = 1'b1;
                    addr_next  = pc;
                end
            end

            // With no request outstanding, FETCH spends one cycle raising the next read.
            FETCH: begin
                if (!bus.mem_rd) begin
                    rd_next   = 1'b1;
                    addr_next = pc;
                end else if (bus.mem_valid) begin
                    rd_next = 1'b0;
                    case (opcode)
                        OP_NOP:  pc_next = pc + ADDR_W'(1);
                        OP_JMP:  pc_next = bus.mem_data[ADDR_W-1:0];
                        OP_HALT: begin
                            state_next  = HALT;
                            halted_next = 1'b1;
                        end
                        default: begin
                            inst_next  = bus.mem_data;
                            state_next = ISSUE;
                        end
                    endcase
                end
            end

            ISSUE: begin
                state_next = WAIT_DONE;
                cnt_next   = '0;
            end

            // done has priority over the timeout in the cycle the limit is reached.
            WAIT_DONE: begin
                if (bus.done) begin
                    pc_next    = pc + ADDR_W'(1);
                    state_next = FETCH;
`ifdef SEQ_RETIRE_COUNT_EN
                    retired_next = retired + 16'd1;
`endif
                end else if (cnt == CNT_LAST) begin
                    state_next = FAULT;
                    fault_next = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            HALT:    state_next = HALT;
            FAULT:   state_next = FAULT;
            default: state_next = IDLE;
        endcase

        start_next = (state_next == ISSUE);
    end

endmodule
